// File: rtl/serial_subtractor_if.sv
// Start/ready/done bus for serial_subtractor; bin is present only when
// SERIAL_SUB_BORROW_IN_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BORROW_IN_EN
    logic             bin;
`endif
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start,
        output a,
        output b,
`ifdef SERIAL_SUB_BORROW_IN_EN
        output bin,
`endif
        input  ready,
        input  done,
        input  d,
        input  bout
    );

    modport slave (
        input  start,
        input  a,
        input  b,
`ifdef SERIAL_SUB_BORROW_IN_EN
        input  bin,
`endif
        output ready,
        output done,
        output d,
        output bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b - bin, one bit per cycle LSB first.
// Define SERIAL_SUB_BORROW_IN_EN to add the bin port seeding the borrow chain.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic [WIDTH:0]   res_ext;
    logic             bin_in, ai, bi, diff, br_next;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign bin_in = bus.bin;
`else
    assign bin_in = 1'b0;
`endif

    assign ai      = a_q[0];
    assign bi      = b_q[0];
    assign diff    = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    assign res_ext = {diff, res_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        bout_d  = bout_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bin_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_ext[WIDTH:1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastBit) begin
                    d_d     = res_ext[WIDTH:1];
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.done  = (state_q == StDone);
    assign bus.d     = d_q;
    assign bus.bout  = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=1 against an arithmetic timing model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic bin8 = 1'b0;
    logic bin1 = 1'b0;
`ifdef SERIAL_SUB_BORROW_IN_EN
    assign if8.bin = bin8;
    assign if1.bin = bin1;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: result from plain arithmetic, timing from edges remaining until idle.
    int         m8_left, m1_left;
    logic [7:0] m8_d, m8_pd;
    logic       m8_bout, m8_pbout;
    logic       m1_d, m1_pd, m1_bout, m1_pbout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_left = 0; m8_d = '0; m8_bout = 1'b0;
        end else if (m8_left == 0) begin
            if (if8.start) begin
                {m8_pbout, m8_pd} = {1'b0, if8.a} - {1'b0, if8.b} - 9'(bin8);
                m8_left = 9;
            end
        end else begin
            m8_left--;
            if (m8_left == 1) begin m8_d = m8_pd; m8_bout = m8_pbout; end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_left = 0; m1_d = 1'b0; m1_bout = 1'b0;
        end else if (m1_left == 0) begin
            if (if1.start) begin
                {m1_pbout, m1_pd} = {1'b0, if1.a} - {1'b0, if1.b} - 2'(bin1);
                m1_left = 2;
            end
        end else begin
            m1_left--;
            if (m1_left == 1) begin m1_d = m1_pd; m1_bout = m1_pbout; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m8_ready", if8.ready, m8_left == 0);
            chk("m8_done", if8.done, m8_left == 1);
            chk("m8_d", if8.d, m8_d);
            chk("m8_bout", if8.bout, m8_bout);
            chk("m1_ready", if1.ready, m1_left == 0);
            chk("m1_done", if1.done, m1_left == 1);
            chk("m1_d", if1.d, m1_d);
            chk("m1_bout", if1.bout, m1_bout);
        end
    end

    // Called just after a negedge; scrambles operands after the accepting edge.
    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] exp_d, input logic exp_bout);
        int lat;
        if8.a = a; if8.b = b; bin8 = bin; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0; if8.a = ~a; if8.b = ~b; bin8 = ~bin;
        lat = 1;
        while (!if8.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 9);
        chk({name, "_d"}, if8.d, exp_d);
        chk({name, "_bout"}, if8.bout, exp_bout);
        @(negedge clk);
        chk({name, "_ready_after"}, if8.ready, 1'b1);
        bin8 = 1'b0;
    endtask

    task automatic op1(input string name, input logic a, input logic b, input logic bin,
                       input logic exp_d, input logic exp_bout);
        int lat;
        if1.a = a; if1.b = b; bin1 = bin; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0; if1.a = ~a; if1.b = ~b; bin1 = ~bin;
        lat = 1;
        while (!if1.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 2);
        chk({name, "_d"}, if1.d, exp_d);
        chk({name, "_bout"}, if1.bout, exp_bout);
        @(negedge clk);
        bin1 = 1'b0;
    endtask

    initial begin
        logic [7:0] tt_d;
        logic [7:0] tt_b;
        int         n;
        int         nd;
        tt_d = 8'b1001_0110;  // indexed by {a,b,bin}
        tt_b = 8'b1000_1110;
        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", if8.ready, 1'b1);
        chk("rst_done", if8.done, 1'b0);
        chk("rst_d", if8.d, 8'h00);
        chk("rst_bout", if8.bout, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        op8("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        op8("borrow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        op8("zero_ff", 8'h00, 8'hFF, 1'b0, 8'h01, 1'b1);
`ifdef SERIAL_SUB_BORROW_IN_EN
        op8("bin_zero", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        op8("bin_10", 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0);
`endif

        // Busy: keep requesting with different operands through RUN and DONE.
        if8.a = 8'h09; if8.b = 8'h04; if8.start = 1'b1;
        @(negedge clk);
        if8.a = 8'hFF; if8.b = 8'h00;
        n = 1;
        while (!if8.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("busy_latency", n, 9);
        chk("busy_d", if8.d, 8'h05);
        @(negedge clk);
        if8.start = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if8.done) nd++;
        end
        chk("busy_extra_done", nd, 0);
        chk("busy_d_held", if8.d, 8'h05);

        // Reset in the middle of RUN, at bit 3.
        if8.a = 8'hA0; if8.b = 8'h01; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", if8.ready, 1'b1);
        chk("midrst_done", if8.done, 1'b0);
        chk("midrst_d", if8.d, 8'h00);
        chk("midrst_bout", if8.bout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op8("after_rst", 8'h02, 8'h01, 1'b0, 8'h01, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
`ifndef SERIAL_SUB_BORROW_IN_EN
            if (idx[0]) continue;
`endif
            op1($sformatf("w1_%0d", i), idx[2], idx[1], idx[0], tt_d[i], tt_b[i]);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
